// File: rtl/cache_line_mem_server_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_pkg
// Shared definitions for the data-cache line refill / writeback path.
// The cache controller and the memory-side responder both import this
// package so that word width, line width and the responder state names
// stay in one place.
//   WORD_W          : width of one memory word
//   WPL_DEFAULT     : default words per cache line
//   LINE_W          : width of a default-sized line
//   state_e         : responder FSM states
//   line_base_index : byte address -> word index of the first word of its line
// ---------------------------------------------------------------------------
package cache_mem_pkg;

   localparam int WORD_W      = 32;
   localparam int WPL_DEFAULT = 4;
   localparam int LINE_W      = WORD_W * WPL_DEFAULT;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      XFER,
      RESP
   } state_e;

   // Drops the byte offset, wraps the word index onto the array depth and
   // clears the word-within-line bits. Both sizes are powers of two, so this
   // reduces to wiring once the arguments are constants.
   function automatic logic [31:0] line_base_index(input logic [63:0] byte_addr,
                                                   input int        wpl,
                                                   input int        mem_depth);
      logic [63:0] word_idx;
      word_idx = (byte_addr >> 2) & 64'(mem_depth - 1);
      word_idx = word_idx & ~64'(wpl - 1);
      return 32'(word_idx);
   endfunction

endpackage

// File: rtl/cache_line_mem_server_if.sv
// ---------------------------------------------------------------------------
// cache_line_mem_server_if
// Line request / response bundle between the data cache (master) and the
// memory-side responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = writeback line, 0 = refill line
//   req_addr            : byte address of the line
//   req_wdata           : writeback line, word 0 in the low bits
//   resp_valid          : one-cycle completion pulse
//   resp_write          : kind of the completing request
//   resp_rdata          : refill line, word 0 in the low bits
//   busy                : responder is working on a request
// ---------------------------------------------------------------------------
interface cache_line_mem_server_if
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int WORDS_PER_LINE = 4
);

   localparam int LW = WORD_W * WORDS_PER_LINE;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [LW-1:0]     req_wdata;
   logic              resp_valid;
   logic              resp_write;
   logic [LW-1:0]     resp_rdata;
   logic              busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_write, resp_rdata, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_write, resp_rdata, busy
   );

endinterface

// File: rtl/cache_line_mem_server_mem_word_array.sv
// ---------------------------------------------------------------------------
// mem_word_array
// Single-port synchronous RAM holding the main-memory words. A read returns
// the addressed word on the cycle after the address is presented; on a
// write cycle the old contents are returned. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module mem_word_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Storage and read register share one port; no reset so this maps onto a block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cache_line_mem_server.sv
// ---------------------------------------------------------------------------
// cache_line_mem_server
// Memory-side responder for the data cache's line refill / writeback path.
// One line request is accepted at a time. A refill waits RD_LATENCY cycles,
// then reads the line one word per cycle and returns it with a one-cycle
// resp_valid pulse. A writeback stores the line one word per cycle and then
// pulses resp_valid.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of cache_line_mem_server_if
// ---------------------------------------------------------------------------
module cache_line_mem_server
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int MEM_DEPTH      = 1024,
   parameter int RD_LATENCY     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   cache_line_mem_server_if.slave  bus
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int WO_W  = $clog2(WORDS_PER_LINE);
   localparam int LW    = WORD_W * WORDS_PER_LINE;

   localparam logic [3:0]      LAT_LAST  = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
   localparam logic [WO_W-1:0] WORD_LAST = WO_W'(WORDS_PER_LINE - 1);

   state_e            state_q, state_d;
   logic [3:0]        lat_cnt_q, lat_cnt_d;
   logic [WO_W-1:0]   word_cnt_q, word_cnt_d;
   logic              write_q, write_d;
   logic [IDX_W-1:0]  base_q, base_d;
   logic [WORD_W-1:0] wdata_q [WORDS_PER_LINE];
   logic [WORD_W-1:0] wdata_d [WORDS_PER_LINE];
   logic [WORD_W-1:0] line_q  [WORDS_PER_LINE];
   logic [WORD_W-1:0] line_d  [WORDS_PER_LINE];
   logic              fill_pending_q, fill_pending_d;
   logic [WO_W-1:0]   fill_idx_q, fill_idx_d;

   logic              ram_we;
   logic [IDX_W-1:0]  ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata;
   logic [LW-1:0]     resp_line;

   mem_word_array #(
      .DEPTH (MEM_DEPTH),
      .AW    (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Next-state logic. The RAM read result of the previous XFER cycle is
   // folded into the line register here. The line base has its word bits
   // cleared, so OR-ing in the word counter forms the word address.
   always_comb begin
      state_d        = state_q;
      lat_cnt_d      = lat_cnt_q;
      word_cnt_d     = word_cnt_q;
      write_d        = write_q;
      base_d         = base_q;
      wdata_d        = wdata_q;
      line_d         = line_q;
      fill_pending_d = 1'b0;
      fill_idx_d     = word_cnt_q;
      ram_we         = 1'b0;
      ram_addr       = base_q | IDX_W'(word_cnt_q);
      ram_wdata      = wdata_q[word_cnt_q];

      if (fill_pending_q) begin
         line_d[fill_idx_q] = ram_rdata;
      end

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d    = bus.req_write;
               base_d     = IDX_W'(line_base_index(64'(bus.req_addr), WORDS_PER_LINE, MEM_DEPTH));
               lat_cnt_d  = 4'd0;
               word_cnt_d = '0;
               for (int w = 0; w < WORDS_PER_LINE; w++) begin
                  wdata_d[w] = bus.req_wdata[w*WORD_W +: WORD_W];
               end
               state_d = (bus.req_write || (RD_LATENCY == 0)) ? XFER : WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
               word_cnt_d = '0;
               state_d    = XFER;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         XFER: begin
            ram_we         = write_q;
            fill_pending_d = !write_q;
            if (word_cnt_q == WORD_LAST) begin
               word_cnt_d = '0;
               state_d    = RESP;
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and capture registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         lat_cnt_q      <= 4'd0;
         word_cnt_q     <= '0;
         write_q        <= 1'b0;
         base_q         <= '0;
         fill_pending_q <= 1'b0;
         fill_idx_q     <= '0;
         for (int w = 0; w < WORDS_PER_LINE; w++) begin
            wdata_q[w] <= '0;
            line_q[w]  <= '0;
         end
      end else begin
         state_q        <= state_d;
         lat_cnt_q      <= lat_cnt_d;
         word_cnt_q     <= word_cnt_d;
         write_q        <= write_d;
         base_q         <= base_d;
         fill_pending_q <= fill_pending_d;
         fill_idx_q     <= fill_idx_d;
         wdata_q        <= wdata_d;
         line_q         <= line_d;
      end
   end

   // The word read in the last XFER cycle is still in the RAM output register
   // during RESP, so it is bypassed onto the response to present a complete line.
   always_comb begin
      resp_line = '0;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
         resp_line[w*WORD_W +: WORD_W] = (fill_pending_q && (fill_idx_q == WO_W'(w))) ? ram_rdata : line_q[w];
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_write = (state_q == RESP) && write_q;
   assign bus.resp_rdata = resp_line;

   // With zero read latency the WAIT state must be unreachable.
   no_wait_when_zero_lat: assert property (@(posedge clk) disable iff (rst)
      (RD_LATENCY == 0) |-> (state_q != WAIT));

endmodule
